// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Load/store access controller in front of the data RAM. Accepts
//            one request at a time over a valid/ready handshake, drives the
//            RAM enable, byte-lane write enables, word address and
//            lane-replicated write data for WAIT_CYCLES+1 access cycles, then
//            returns the extracted and extended load data (or zero for
//            stores) through a registered response handshake.
// Ports    : clk, rst (asynchronous, active-low)
//            req_valid/req_ready, req_write, req_size, req_signed,
//            req_addr, req_wdata           - request channel
//            resp_valid/resp_ready, resp_rdata, resp_err - response channel
//            ram_en, ram_write_en, ram_addr, ram_write_data, ram_read_data
//                                          - RAM side
// Options  : MEM_ALIGN_CHECK_EN - when defined, misaligned halfword/word
//            requests skip the RAM access and respond with resp_err=1.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_en,
    output logic [3:0]  ram_write_en,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    localparam logic [1:0] c_SZ_BYTE   = 2'b00;
    localparam logic [1:0] c_SZ_HALF   = 2'b01;

    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_final;
    logic [3:0]  w_lanes;
    logic [4:0]  w_shamt;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;
    logic [31:0] w_wdata_rep;

    // Last cycle of the access phase: the only cycle a store may write and
    // the cycle whose closing edge captures load data.
    assign w_final = (r_state == c_ST_ACCESS) && (r_cnt == 4'd0);

    // Lane selection and data replication; a halfword only looks at addr[1]
    // and a word ignores the low address bits entirely.
    always_comb begin
        w_lanes     = 4'b1111;
        w_shamt     = 5'd0;
        w_wdata_rep = r_wdata;
        case (r_size)
            c_SZ_BYTE: begin
                w_lanes     = 4'b0001 << r_addr[1:0];
                w_shamt     = {r_addr[1:0], 3'b000};
                w_wdata_rep = {4{r_wdata[7:0]}};
            end
            c_SZ_HALF: begin
                w_lanes     = r_addr[1] ? 4'b1100 : 4'b0011;
                w_shamt     = {r_addr[1], 4'b0000};
                w_wdata_rep = {2{r_wdata[15:0]}};
            end
            default: begin
                w_lanes     = 4'b1111;
                w_shamt     = 5'd0;
                w_wdata_rep = r_wdata;
            end
        endcase
    end

    assign w_shifted = ram_read_data >> w_shamt;

    always_comb begin
        w_load_data = w_shifted;
        case (r_size)
            c_SZ_BYTE: w_load_data = {{24{r_signed & w_shifted[7]}},  w_shifted[7:0]};
            c_SZ_HALF: w_load_data = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
            default:   w_load_data = w_shifted;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic r_err;
    logic w_req_misaligned;

    assign w_req_misaligned = ((req_size == c_SZ_HALF) && req_addr[0]) ||
                              (req_size[1] && (req_addr[1:0] != 2'b00));
    assign resp_err         = r_err;
`else
    assign resp_err         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= 4'd0;
            r_write  <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
            r_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_cnt    <= c_WAIT_LOAD;
`ifdef MEM_ALIGN_CHECK_EN
                        // Misaligned requests bypass the RAM entirely.
                        if (w_req_misaligned) begin
                            r_state <= c_ST_RESP;
                            r_err   <= 1'b1;
                            r_rdata <= 32'd0;
                        end else begin
                            r_state <= c_ST_ACCESS;
                            r_err   <= 1'b0;
                        end
`else
                        r_state  <= c_ST_ACCESS;
`endif
                    end
                end
                c_ST_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_ST_RESP;
                        r_rdata <= r_write ? 32'd0 : w_load_data;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ST_RESP: begin
                    if (resp_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // All outputs decode registered state only, so the asynchronous reset
    // drops the RAM controls immediately and no req_*/resp_ready path exists.
    assign req_ready      = (r_state == c_ST_IDLE);
    assign resp_valid     = (r_state == c_ST_RESP);
    assign resp_rdata     = r_rdata;
    assign ram_en         = (r_state == c_ST_ACCESS);
    assign ram_write_en   = (w_final && r_write) ? w_lanes : 4'b0000;
    assign ram_addr       = {r_addr[31:2], 2'b00};
    assign ram_write_data = w_wdata_rep;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench for mem_access_ctrl with a RAM model and a
//            transaction-level reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int WAIT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;

    mem_access_ctrl #(.WAIT_CYCLES(WAIT)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .ram_en         (ram_en),
        .ram_write_en   (ram_write_en),
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 64) return 32'h80FF7F01;
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5C31E07;
    endfunction

    // RAM seen by the DUT (written only through the DUT's lane enables) and
    // the reference memory updated by the bench's own store rules.
    logic [31:0] ram [0:127];
    logic [31:0] mdl [0:127];
    bit          init_done = 1'b0;

    assign ram_read_data = ram[ram_addr[8:2]];

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 128; i++) ram[i] <= init_word(i);
        end else begin
            for (int i = 0; i < 4; i++)
                if (ram_write_en[i]) ram[ram_addr[8:2]][8*i +: 8] <= ram_write_data[8*i +: 8];
        end
    end

    // Cycle-level expectations, refreshed by the driver just after each edge.
    logic        exp_ready = 1'b1;
    logic        exp_valid = 1'b0;
    logic        exp_en    = 1'b0;
    logic [3:0]  exp_we    = 4'd0;
    logic [31:0] exp_addr  = 32'd0;
    logic [31:0] exp_wd    = 32'd0;
    logic [31:0] exp_rdata = 32'd0;
    logic        exp_err   = 1'b0;

    always @(negedge clk) begin
        chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_valid});
        chk("ram_en", {31'd0, ram_en}, {31'd0, exp_en});
        chk("ram_write_en", {28'd0, ram_write_en}, {28'd0, exp_we});
        if (exp_en) chk("ram_addr", ram_addr, exp_addr);
        if (exp_we != 4'd0) chk("ram_write_data", ram_write_data, exp_wd);
        if (exp_valid) begin
            chk("resp_rdata", resp_rdata, exp_rdata);
            chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
        end
    end

    logic [3:0]  obs_we;
    logic [31:0] obs_wd;
    logic [31:0] obs_rdata;
    logic        obs_err;

    // One complete transaction; entered and left one time unit after an edge
    // with the DUT idle.
    task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [31:0] addr, input logic [31:0] wd, input int delay);
        bit          mis;
        logic [3:0]  ln;
        logic [31:0] rep, word, v;
        int          idx;
        idx = int'(addr[8:2]);
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = ((sz == 2'b01) && addr[0]) || (sz[1] && (addr[1:0] != 2'b00));
`endif
        case (sz)
            2'b00:   begin ln = 4'b0001 << addr[1:0]; rep = {4{wd[7:0]}}; end
            2'b01:   begin ln = addr[1] ? 4'b1100 : 4'b0011; rep = {2{wd[15:0]}}; end
            default: begin ln = 4'b1111; rep = wd; end
        endcase
        word = mdl[idx];
        if (sz == 2'b00) begin
            v = (word >> (8 * int'(addr[1:0]))) & 32'h0000_00FF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (word >> (16 * int'(addr[1]))) & 32'h0000_FFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end

        req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        // Garbage on the request port must be ignored outside IDLE.
        req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom);
        req_size = 2'($urandom); req_signed = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        exp_ready = 1'b0;
        if (!mis) begin
            for (int k = 0; k <= WAIT; k++) begin
                exp_en   = 1'b1;
                exp_addr = {addr[31:2], 2'b00};
                exp_we   = (wr && k == WAIT) ? ln : 4'd0;
                exp_wd   = rep;
                if (k == WAIT) begin obs_we = ram_write_en; obs_wd = ram_write_data; end
                @(posedge clk); #1;
            end
        end
        if (wr && !mis)
            for (int i = 0; i < 4; i++) if (ln[i]) mdl[idx][8*i +: 8] = rep[8*i +: 8];
        exp_en    = 1'b0;
        exp_we    = 4'd0;
        exp_valid = 1'b1;
        exp_rdata = (wr || mis) ? 32'd0 : v;
        exp_err   = mis;
        obs_rdata = resp_rdata;
        obs_err   = resp_err;
        resp_ready = 1'b0;
        for (int d = 0; d < delay; d++) begin @(posedge clk); #1; end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        exp_ready  = 1'b1;
        exp_valid  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mdl[i] = init_word(i);
        #1;
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wdata", ram_write_data, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        @(posedge clk); #1;
        init_done = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        do_req(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'd0, 0);
        chk("lit_sbyte_103", obs_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'd0, 0);
        chk("lit_uhalf_102", obs_rdata, 32'h0000_80FF);
        do_req(1'b0, 2'b01, 1'b1, 32'h0000_0100, 32'd0, 0);
        chk("lit_shalf_100", obs_rdata, 32'h0000_7F01);
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'd0, 5);
`ifdef MEM_ALIGN_CHECK_EN
        chk("lit_misal_rdata", obs_rdata, 32'd0);
        chk("lit_misal_err", {31'd0, obs_err}, 32'd1);
`else
        chk("lit_word_102", obs_rdata, 32'h80FF_7F01);
        chk("lit_word_err", {31'd0, obs_err}, 32'd0);
`endif
        do_req(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h1122_3344, 0);
        chk("lit_sw_we", {28'd0, obs_we}, 32'h0000_000F);
        chk("lit_sw_wd", obs_wd, 32'h1122_3344);
        chk("lit_sw_rdata", obs_rdata, 32'd0);
        do_req(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00AB, 0);
        chk("lit_sb_we", {28'd0, obs_we}, 32'h0000_0008);
        chk("lit_sb_wd", obs_wd, 32'hABAB_ABAB);
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0, 1);
        chk("lit_lw_after_st", obs_rdata, 32'hAB22_3344);

        // Reset in the first access cycle of a store.
        req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h0000_0104; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_ready = 1'b0; exp_en = 1'b1; exp_addr = 32'h0000_0104; exp_we = 4'd0;
        #1;
        rst = 1'b0;
        exp_ready = 1'b1; exp_en = 1'b0; exp_we = 4'd0; exp_valid = 1'b0;
        #1;
        chk("rst_async_en", {31'd0, ram_en}, 32'd0);
        chk("rst_async_we", {28'd0, ram_write_en}, 32'd0);
        chk("rst_async_addr", ram_addr, 32'd0);
        chk("rst_async_wdata", ram_write_data, 32'd0);
        chk("rst_async_rdata", resp_rdata, 32'd0);
        chk("rst_async_valid", {31'd0, resp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_ram_kept", ram[65], mdl[65]);
        chk("rst_ready_after", {31'd0, req_ready}, 32'd1);

        for (int n = 0; n < 300; n++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
                   int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 128; i++) chk("final_ram", ram[i], mdl[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
